// File: rtl/skylark_pkg.sv
// Shared ALU control encodings and RV32I opcode/funct constants
// for the decode-to-execute control stage.
package skylark_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_func_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decoder.sv
// Pure combinational RV32I decode into ALU control: function, operand-B
// source, extended immediate, register write enable and illegal flag.
module alu_decoder
  import skylark_pkg::*;
(
  input  logic [31:0] i_instr,
  output alu_func_t   o_func,
  output logic        o_opbsrc,
  output logic [31:0] o_extimm,
  output logic        o_regwrite,
  output logic        o_illegal,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_f7_zero;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_shamt;
  alu_func_t   w_func;
  logic        w_opbsrc;
  logic [31:0] w_imm;
  logic        w_regwrite;
  logic        w_illegal;

  assign w_opcode  = i_instr[6:0];
  assign w_funct3  = i_instr[14:12];
  assign w_funct7  = i_instr[31:25];
  assign w_f7_zero = (w_funct7 == F7_ZERO);
  assign w_imm_i   = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_shamt   = {27'd0, i_instr[24:20]};

  always_comb begin
    w_func     = ALU_ADD;
    w_opbsrc   = 1'b0;
    w_imm      = '0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_regwrite = 1'b1;
        case (w_funct3)
          3'b000: begin
            if (w_f7_zero)               w_func = ALU_ADD;
            else if (w_funct7 == F7_ALT) w_func = ALU_SUB;
            else                         w_illegal = 1'b1;
          end
          3'b001:  begin w_func = ALU_SLL; w_illegal = !w_f7_zero; end
          3'b010:  begin w_func = ALU_SLT; w_illegal = !w_f7_zero; end
          3'b100:  begin w_func = ALU_XOR; w_illegal = !w_f7_zero; end
          3'b101:  begin w_func = ALU_SRL; w_illegal = !w_f7_zero; end
          3'b110:  begin w_func = ALU_OR;  w_illegal = !w_f7_zero; end
          3'b111:  begin w_func = ALU_AND; w_illegal = !w_f7_zero; end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_regwrite = 1'b1;
        w_opbsrc   = 1'b1;
        w_imm      = w_imm_i;
        case (w_funct3)
          3'b000:  w_func = ALU_ADD;
          3'b010:  w_func = ALU_SLT;
          3'b100:  w_func = ALU_XOR;
          3'b110:  w_func = ALU_OR;
          3'b111:  w_func = ALU_AND;
          // shifts carry a zero-extended shamt; funct7 must be clear
          3'b001:  begin w_func = ALU_SLL; w_imm = w_shamt; w_illegal = !w_f7_zero; end
          3'b101:  begin w_func = ALU_SRL; w_imm = w_shamt; w_illegal = !w_f7_zero; end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_opbsrc   = 1'b1;
        w_imm      = w_imm_i;
        w_regwrite = 1'b1;
      end
      OPC_STORE: begin
        w_opbsrc = 1'b1;
        w_imm    = w_imm_s;
      end
      OPC_BRANCH: begin
        w_func = ALU_SUB;
        w_imm  = w_imm_b;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_func     = ALU_ADD;
      w_regwrite = 1'b0;
      w_opbsrc   = 1'b0;
      w_imm      = '0;
    end
  end

  assign o_func     = w_func;
  assign o_opbsrc   = w_opbsrc;
  assign o_extimm   = w_imm;
  assign o_regwrite = w_regwrite;
  assign o_illegal  = w_illegal;
  assign o_rs1      = i_instr[19:15];
  assign o_rs2      = i_instr[24:20];
  assign o_rd       = i_instr[11:7];

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX control register with stall/flush handling and an illegal-instruction
// trap FSM in front of the ALU.
//
//   state   | meaning
//   ST_RUN  | accepting instructions from D
//   ST_TRAP | illegal instruction issued; inserting bubbles until TrapAck/FlushE
module alu_ctrl_stage
  import skylark_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [31:0]     InstrD,
  input  logic            ValidD,
  output logic            ReadyD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            TrapAck,
  output logic [2:0]      ALUFuncE,
  output logic            OpBSrcE,
  output logic [XLEN-1:0] ExtImmE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            ValidE,
  output logic            IllegalE
);

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  alu_func_t   w_func;
  logic        w_opbsrc;
  logic [31:0] w_extimm;
  logic        w_regwrite;
  logic        w_illegal;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_load;

  alu_func_t       r_func;
  logic            r_opbsrc;
  logic [XLEN-1:0] r_extimm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic            r_regwrite;
  logic            r_valid;
  logic            r_illegal;

  alu_decoder u_dec (
    .i_instr    (InstrD),
    .o_func     (w_func),
    .o_opbsrc   (w_opbsrc),
    .o_extimm   (w_extimm),
    .o_regwrite (w_regwrite),
    .o_illegal  (w_illegal),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rd       (w_rd)
  );

  // a real instruction is captured only in RUN with no stall and no flush
  assign w_load = (r_state == ST_RUN) && !StallE && !FlushE && ValidD;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_load && w_illegal) w_state_nxt = ST_TRAP;
      ST_TRAP: if (TrapAck || FlushE)   w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_RUN;
      r_func     <= ALU_ADD;
      r_opbsrc   <= 1'b0;
      r_extimm   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (FlushE || !StallE) begin
        if (w_load) begin
          r_func     <= w_func;
          r_opbsrc   <= w_opbsrc;
          r_extimm   <= w_extimm;
          r_rs1      <= w_rs1;
          r_rs2      <= w_rs2;
          r_rd       <= w_rd;
          r_regwrite <= w_regwrite;
          r_valid    <= 1'b1;
          r_illegal  <= w_illegal;
        end else begin
          r_func     <= ALU_ADD;
          r_opbsrc   <= 1'b0;
          r_extimm   <= '0;
          r_rs1      <= '0;
          r_rs2      <= '0;
          r_rd       <= '0;
          r_regwrite <= 1'b0;
          r_valid    <= 1'b0;
          r_illegal  <= 1'b0;
        end
      end
    end
  end

  assign ReadyD    = (r_state == ST_RUN) && !StallE;
  assign ALUFuncE  = r_func;
  assign OpBSrcE   = r_opbsrc;
  assign ExtImmE   = r_extimm;
  assign Rs1E      = r_rs1;
  assign Rs2E      = r_rs2;
  assign RdE       = r_rd;
  assign RegWriteE = r_regwrite;
  assign ValidE    = r_valid;
  assign IllegalE  = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: hand-decoded expectations plus a
// small stall/flush/trap model of the E register.
module tb_alu_ctrl_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        ReadyD;
  logic        StallE;
  logic        FlushE;
  logic        TrapAck;
  logic [2:0]  ALUFuncE;
  logic        OpBSrcE;
  logic [31:0] ExtImmE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        ValidE;
  logic        IllegalE;

  alu_ctrl_stage #(.XLEN(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .InstrD    (InstrD),
    .ValidD    (ValidD),
    .ReadyD    (ReadyD),
    .StallE    (StallE),
    .FlushE    (FlushE),
    .TrapAck   (TrapAck),
    .ALUFuncE  (ALUFuncE),
    .OpBSrcE   (OpBSrcE),
    .ExtImmE   (ExtImmE),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RegWriteE (RegWriteE),
    .ValidE    (ValidE),
    .IllegalE  (IllegalE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  func;
    logic        opb;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic        ill;
    logic        dc_opb;
    logic        dc_imm;
  } e_t;

  e_t   sb_q[$];
  e_t   m_e;
  logic m_trap;
  int   n_chk  = 0;
  int   n_pass = 0;

  e_t bub, d_addi, d_sub, d_slli, d_sw, d_beq, d_bne, d_lw, d_xori, d_and,
      d_srli, d_sra, d_sltiu, d_srai, d_opc0, d_mul;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic e_t mk(input logic [2:0] func, input logic opb, input logic [31:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic rw, input logic ill, input logic dco, input logic dci);
    e_t e;
    e.func = func; e.opb = opb; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.rw = rw; e.valid = 1'b1; e.ill = ill; e.dc_opb = dco; e.dc_imm = dci;
    return e;
  endfunction

  task automatic cmp_e(input string tag);
    e_t e;
    chk({tag, ".sb_size"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ".func"},  {29'd0, ALUFuncE}, {29'd0, e.func});
      if (!e.dc_opb) chk({tag, ".opb"}, {31'd0, OpBSrcE}, {31'd0, e.opb});
      if (!e.dc_imm) chk({tag, ".imm"}, ExtImmE, e.imm);
      chk({tag, ".rs1"},   {27'd0, Rs1E}, {27'd0, e.rs1});
      chk({tag, ".rs2"},   {27'd0, Rs2E}, {27'd0, e.rs2});
      chk({tag, ".rd"},    {27'd0, RdE},  {27'd0, e.rd});
      chk({tag, ".rw"},    {31'd0, RegWriteE}, {31'd0, e.rw});
      chk({tag, ".valid"}, {31'd0, ValidE},    {31'd0, e.valid});
      chk({tag, ".ill"},   {31'd0, IllegalE},  {31'd0, e.ill});
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic vd, input logic st,
                      input logic fl, input logic ack, input e_t dec, input string tag);
    @(negedge CLK);
    InstrD = instr; ValidD = vd; StallE = st; FlushE = fl; TrapAck = ack;
    #1;
    chk({tag, ".ready"}, {31'd0, ReadyD}, {31'd0, (!m_trap && !st)});
    if (fl) begin
      m_e = bub; m_trap = 1'b0;
    end else if (st) begin
      if (m_trap && ack) m_trap = 1'b0;
    end else if (!m_trap) begin
      m_e = vd ? dec : bub;
      if (vd && dec.ill) m_trap = 1'b1;
    end else begin
      m_e = bub;
      if (ack) m_trap = 1'b0;
    end
    sb_q.push_back(m_e);
    @(posedge CLK);
    #1;
    cmp_e(tag);
  endtask

  initial begin
    bub = '{default: '0};
    //           func    opb  imm           rs1 rs2 rd  rw ill dco dci
    d_addi  = mk(3'b000, 1, 32'hFFFF_FFFB,  0, 27,  1, 1, 0, 0, 0);
    d_sub   = mk(3'b001, 0, 32'h0,          1,  2,  3, 1, 0, 0, 1);
    d_slli  = mk(3'b110, 1, 32'd3,          5,  3,  5, 1, 0, 0, 0);
    d_sw    = mk(3'b000, 1, 32'd8,          1,  2,  8, 0, 0, 0, 0);
    d_beq   = mk(3'b001, 0, 32'd16,         1,  2, 16, 0, 0, 0, 0);
    d_bne   = mk(3'b001, 0, 32'hFFFF_FFF8,  0,  0, 25, 0, 0, 0, 0);
    d_lw    = mk(3'b000, 1, 32'hFFFF_FFFC,  2, 28,  6, 1, 0, 0, 0);
    d_xori  = mk(3'b100, 1, 32'h0000_07FF,  1, 31,  7, 1, 0, 0, 0);
    d_and   = mk(3'b010, 0, 32'h0,          1,  2,  4, 1, 0, 0, 1);
    d_srli  = mk(3'b111, 1, 32'd31,         1, 31,  1, 1, 0, 0, 0);
    d_sra   = mk(3'b000, 0, 32'h0,          1,  2,  1, 0, 1, 1, 1);
    d_sltiu = mk(3'b000, 0, 32'h0,          0,  0,  0, 0, 1, 1, 1);
    d_srai  = mk(3'b000, 0, 32'h0,          1, 31,  1, 0, 1, 1, 1);
    d_opc0  = mk(3'b000, 0, 32'h0,          0,  0,  0, 0, 1, 1, 1);
    d_mul   = mk(3'b000, 0, 32'h0,          1,  2,  3, 0, 1, 1, 1);

    nRST = 1'b0; InstrD = 32'h0; ValidD = 1'b0;
    StallE = 1'b0; FlushE = 1'b0; TrapAck = 1'b0;
    m_e = bub; m_trap = 1'b0;

    #12;
    sb_q.push_back(bub);
    cmp_e("reset");
    chk("reset.ready", {31'd0, ReadyD}, 32'd1);
    @(negedge CLK) nRST = 1'b1;

    step(32'hFFB00093, 1, 0, 0, 0, d_addi,  "addi");
    step(32'h402081B3, 1, 0, 0, 0, d_sub,   "sub");
    step(32'h00329293, 1, 0, 0, 0, d_slli,  "slli");
    step(32'h0020A423, 1, 0, 0, 0, d_sw,    "sw");
    step(32'h00208863, 1, 0, 0, 0, d_beq,   "beq");
    step(32'hFE001CE3, 1, 0, 0, 0, d_bne,   "bne_neg");
    step(32'hFFC12303, 1, 0, 0, 0, d_lw,    "lw");
    step(32'h7FF0C393, 1, 0, 0, 0, d_xori,  "xori");
    step(32'h0020F233, 1, 0, 0, 0, d_and,   "and");
    step(32'h01F0D093, 1, 0, 0, 0, d_srli,  "srli");
    step(32'hFFB00093, 0, 0, 0, 0, d_addi,  "novalid");
    step(32'h4020D0B3, 0, 0, 0, 0, d_sra,   "ill_novalid");
    step(32'hFFB00093, 1, 0, 0, 1, d_addi,  "ack_in_run");

    step(32'h4020D0B3, 1, 0, 0, 0, d_sra,   "sra");
    for (int i = 0; i < 3; i++)
      step(32'h7FF0C393, 1, 0, 0, 0, d_xori, "trap_bubble");
    step(32'h7FF0C393, 1, 0, 0, 1, d_xori,  "trap_ack");
    step(32'hFFB00093, 1, 0, 0, 0, d_addi,  "after_ack");

    step(32'h402081B3, 1, 1, 0, 0, d_sub,   "stall1");
    step(32'h402081B3, 1, 1, 0, 0, d_sub,   "stall2");
    step(32'h402081B3, 1, 1, 1, 0, d_sub,   "flush_stall");
    step(32'h402081B3, 1, 0, 0, 0, d_sub,   "sub_again");

    step(32'h00003013, 1, 0, 0, 0, d_sltiu, "sltiu");
    step(32'h0020F233, 1, 0, 1, 1, d_and,   "flush_ack");
    step(32'h0020F233, 1, 0, 0, 0, d_and,   "and_again");

    step(32'h41F0D093, 1, 0, 0, 0, d_srai,  "srai");
    step(32'h0020F233, 1, 1, 0, 0, d_and,   "ill_stalled");
    step(32'h0020F233, 1, 0, 0, 0, d_and,   "ill_bubble");
    step(32'h0020F233, 1, 0, 1, 0, d_and,   "trap_flush");

    step(32'h022081B3, 1, 0, 0, 0, d_mul,   "bad_funct7");
    step(32'h0020F233, 1, 0, 0, 1, d_and,   "mul_ack");

    step(32'h00000000, 1, 0, 0, 0, d_opc0,  "opc_zero");
    step(32'h0020F233, 1, 0, 0, 0, d_and,   "opc_trap");
    @(negedge CLK);
    StallE = 1'b0; FlushE = 1'b0; TrapAck = 1'b0;
    #2 nRST = 1'b0;
    #1;
    m_e = bub; m_trap = 1'b0;
    sb_q.push_back(bub);
    cmp_e("rst_mid");
    chk("rst_mid.ready", {31'd0, ReadyD}, 32'd1);
    @(negedge CLK) nRST = 1'b1;
    step(32'h7FF0C393, 1, 0, 0, 0, d_xori,  "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Decode-to-execute stage that turns a raw RV32I instruction into the ALU's control encoding (function select, operand-B source, extended immediate) and registers it into the E stage. It sits between the fetch/decode pipeline register and the ALU. It generates the control that the ALU consumes, and it owns the ID/EX register for those fields. It handles stall, flush and illegal-instruction trap via a small FSM.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; only 32 is supported.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset; asynchronous, active-low.
- `InstrD` in 32: instruction word from the D stage.
- `ValidD` in 1: `InstrD` holds a real instruction.
- `ReadyD` out 1: the stage accepts `InstrD` this cycle.
- `StallE` in 1: hold the E register (hazard unit).
- `FlushE` in 1: replace E contents with a bubble.
- `TrapAck` in 1: trap handler acknowledges the illegal instruction.
- `ALUFuncE` out 3: ALU function. Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- `OpBSrcE` out 1: 1 selects `ExtImmE` as operand B, 0 selects rs2.
- `ExtImmE` out 32: extended immediate.
- `Rs1E`, `Rs2E`, `RdE` out 5 each: register indices.
- `RegWriteE` out 1: instruction writes `RdE`.
- `ValidE` out 1: E register holds a live instruction.
- `IllegalE` out 1: E instruction is unsupported.

## Operation
Decode, combinational on `InstrD`:
- OP (0110011), `OpBSrc`=0, `RegWrite`=1. By funct3:
  - 000: ADD if funct7=0000000, SUB if funct7=0100000.
  - 001 SLL; 010 SLT; 100 XOR; 101 SRL (funct7=0); 110 OR; 111 AND.
  - Illegal: 011 (SLTU), 101 with funct7=0100000 (SRA), and any other funct7.
- OP-IMM (0010011), `OpBSrc`=1, `RegWrite`=1:
  - Immediate is I-type `Instr[31:20]`, sign-extended.
  - SLLI and SRLI take shamt `Instr[24:20]`, zero-extended; they require funct7=0.
  - SLTIU and SRAI are illegal.
  - There is no SUBI; a negative ADDI immediate covers subtraction.
- LOAD (0000011): ADD, `OpBSrc`=1, I-immediate, `RegWrite`=1.
- STORE (0100011): ADD, `OpBSrc`=1, S-immediate `{Instr[31:25],Instr[11:7]}` sign-extended, `RegWrite`=0.
- BRANCH (1100011): SUB, `OpBSrc`=0, `ExtImm` = B-immediate sign-extended, `RegWrite`=0.
- Any other opcode is illegal. Illegal decode forces `RegWrite`=0 and `ALUFunc`=000.
- `Rs1`/`Rs2`/`Rd` come from `Instr[19:15]`/`[24:20]`/`[11:7]` unconditionally.

FSM states: RUN, TRAP.
- RUN → TRAP: on the edge that loads an instruction with `ValidD`=1 and illegal decode.
- TRAP → RUN: on `TrapAck`=1 or `FlushE`=1.
- `ReadyD` = (state==RUN) && !`StallE`.

E-register update, in priority order:
1. `nRST` low: all outputs 0, state RUN.
2. `FlushE`: bubble. `ValidE`, `IllegalE` and `RegWriteE` are 0; other fields are don't-care but driven 0.
3. `StallE`: hold all fields.
4. State RUN: load the decode. `ValidE`=`ValidD`. If `ValidD`=0, load a bubble.
5. State TRAP: load a bubble. `InstrD` is not consumed.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the E outputs after edge N.
- Reset values: `ALUFuncE`=000, `OpBSrcE`=0, `ExtImmE`=0, `Rs1E`/`Rs2E`/`RdE`=0, `RegWriteE`=0, `ValidE`=0, `IllegalE`=0, state RUN.
- After reset, `ReadyD` is 1 whenever `StallE`=0.
- An illegal instruction is visible for exactly one cycle with `IllegalE`=1, unless `StallE` holds it longer.
- While in TRAP, `ReadyD`=0 and bubbles follow.
- `FlushE` and `StallE` together: the flush wins.
- `FlushE` and `TrapAck` in the same cycle: bubble, state RUN.
- `TrapAck` while in RUN: no effect.
- Reset asserted mid-trap returns to RUN immediately; no edge is needed.
- `ReadyD` is combinational from `StallE` and state. There is no combinational path from `InstrD` to any output.

## Structure
- `skylark_pkg` holds:
  - `alu_func_t`, a 3-bit enum (ADD…SRL) with the encodings above;
  - opcode constants `OPC_OP`, `OPC_OPIMM`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`;
  - funct7 constants.
- The FSM state enum stays local to the module.
- One sub-module, `alu_decoder`, does the pure combinational decode from `Instr` to {func, opbsrc, extimm, regwrite, illegal}. The top holds the FSM and the E register.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093), `ValidD`=1 → next edge: `ALUFuncE`=000, `OpBSrcE`=1, `ExtImmE`=0xFFFFFFFB, `RdE`=1, `RegWriteE`=1, `ValidE`=1.
- SUB x3,x1,x2 (0x402081B3) → `ALUFuncE`=001, `OpBSrcE`=0, `Rs1E`=1, `Rs2E`=2, `RdE`=3. SLLI x5,x5,3 (0x00329293) → `ALUFuncE`=110, `ExtImmE`=3.
- SW x2,8(x1) (0x0020A423) → `ALUFuncE`=000, `OpBSrcE`=1, `ExtImmE`=8, `RegWriteE`=0.
- SRA (0x4020D0B3) → `IllegalE`=1 and `RegWriteE`=0 for one cycle. Then `ReadyD`=0 with `ValidE`=0 for 3 cycles. `TrapAck` pulse → `ReadyD`=1 next cycle.
- Load ADDI, then `StallE`=1 for 2 cycles with a new `InstrD` → E fields held and `ReadyD`=0. Then `FlushE`+`StallE` together → `ValidE`=0.
- Assert `nRST` low asynchronously mid-TRAP → all outputs 0 and state RUN before the next edge. `ReadyD`=1 with `StallE`=0.
